fifo_rd_burst_ctrl: RTL

Read-side consumer that drains an async threshold FIFO (show-ahead read data, read-domain occupancy count, empty flag) into a burst-oriented downstream master interface. It waits for a full burst, or flushes a partial burst after an idle timeout. It then issues a burst request with a length, and pops one FIFO word per accepted data beat. It sits in the FIFO read clock domain, between the FIFO and a bus master or DMA engine.

---
 rtl/fifo_burst_pkg.sv | 18 +
 rtl/fifo_rd_burst_ctrl_if.sv | 23 ++
 rtl/fifo_burst_tmr.sv | 35 +++
 rtl/fifo_rd_burst_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/fifo_burst_pkg.sv
// rtl/fifo_burst_pkg.sv - shared types and widths for the FIFO read burst controller
package fifo_burst_pkg;

  localparam int AW_DEF = 2;
  localparam int CNT_W  = AW_DEF + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } burst_state_e;

  // Occupancy/length fields carry one extra bit so a completely full FIFO is representable.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_burst_ctrl_if.sv
// rtl/fifo_rd_burst_ctrl_if.sv - burst request/beat bus between controller and downstream master
interface fifo_rd_burst_ctrl_if #(
  parameter int W  = 8,
  parameter int AW = 2
);
  logic          m_req;
  logic [AW:0]   m_len;
  logic          m_ack;
  logic [W-1:0]  m_data;
  logic          m_dvalid;
  logic          m_dready;
  logic          m_dlast;

  modport master (
    output m_req, m_len, m_data, m_dvalid, m_dlast,
    input  m_ack, m_dready
  );

  modport slave (
    input  m_req, m_len, m_data, m_dvalid, m_dlast,
    output m_ack, m_dready
  );
endinterface

// File: rtl/fifo_burst_tmr.sv
// rtl/fifo_burst_tmr.sv - saturating idle counter that flags a partial-burst timeout
module fifo_burst_tmr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_MAX);
endmodule

// File: rtl/fifo_rd_burst_ctrl.sv
// rtl/fifo_rd_burst_ctrl.sv - drains a show-ahead FIFO into length-prefixed bursts
module fifo_rd_burst_ctrl
  import fifo_burst_pkg::*;
#(
  parameter int W         = 8,
  parameter int AW        = AW_DEF,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_en,
  input  logic [W-1:0]         fifo_rd_data,
  input  logic                 fifo_empty,
  input  logic [AW:0]          fifo_rd_aval,
  output logic                 fifo_rd_en,
  output logic                 busy,
  fifo_rd_burst_ctrl_if.master m_if
);
  localparam int CW = cnt_width(AW);
  localparam logic [CW-1:0] BURST_LEN = CW'(BURST_MAX);

  burst_state_e  state_q, state_d;
  logic          m_req_q, m_req_d;
  logic [CW-1:0] m_len_q, m_len_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic start_full;
  logic partial;
  logic tmr_clear;
  logic tmr_inc;
  logic tmr_expired;
  logic beat_valid;
  logic beat_acc;

  assign start_full = cfg_en && (fifo_rd_aval >= BURST_LEN);
  assign partial    = cfg_en && (fifo_rd_aval != '0) && (fifo_rd_aval < BURST_LEN);

  // Popping is gated by !fifo_empty even though a latched length never exceeds occupancy.
  assign beat_valid = (state_q == XFER) && !fifo_empty;
  assign beat_acc   = beat_valid && m_if.m_dready;

  fifo_burst_tmr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmr (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tmr_clear),
    .inc    (tmr_inc),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_len_d    = m_len_q;
    beat_cnt_d = beat_cnt_q;
    tmr_clear  = 1'b1;
    tmr_inc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_clear = !partial;
        tmr_inc   = partial;
        if (start_full) begin
          m_len_d   = BURST_LEN;
          m_req_d   = 1'b1;
          state_d   = REQ;
          tmr_clear = 1'b1;
        end else if (partial && tmr_expired) begin
          m_len_d   = fifo_rd_aval;
          m_req_d   = 1'b1;
          state_d   = REQ;
          tmr_clear = 1'b1;
        end
      end
      REQ: begin
        if (m_if.m_ack) begin
          m_req_d    = 1'b0;
          beat_cnt_d = m_len_q;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q - CW'(1);
          if (beat_cnt_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_len_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      m_req_q    <= m_req_d;
      m_len_q    <= m_len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign fifo_rd_en    = beat_acc;
  assign busy          = (state_q != IDLE);
  assign m_if.m_req    = m_req_q;
  assign m_if.m_len    = m_len_q;
  assign m_if.m_data   = fifo_rd_data;
  assign m_if.m_dvalid = beat_valid;
  assign m_if.m_dlast  = beat_valid && (beat_cnt_q == CW'(1));
endmodule
